// File: rtl/lm75a_temp_pkg.sv
// Shared constants, FSM encoding and small helpers for the LM75A temperature monitor.
package lm75a_temp_pkg;

    localparam int unsigned TEMP_W     = 11;
    localparam int unsigned FRAC_BITS  = 3;
    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned INT_W      = TEMP_W - FRAC_BITS;
    localparam int unsigned SUM_W      = TEMP_W + 2;

    localparam logic signed [TEMP_W-1:0] T_OS_DEFAULT   = 11'sd640;
    localparam logic signed [TEMP_W-1:0] T_HYST_DEFAULT = 11'sd600;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // -1024 maps to 11'h400, which is the correct magnitude read as unsigned.
    function automatic logic [TEMP_W-1:0] temp_abs(input logic signed [TEMP_W-1:0] t);
        return t[TEMP_W-1] ? unsigned'(-t) : unsigned'(t);
    endfunction

    function automatic logic [3:0] frac_tenths(input logic [FRAC_BITS-1:0] f);
        logic [5:0] p;
        p = 6'(f) * 6'd5;
        return p[5:2];
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_sum(input logic signed [TEMP_W-1:0] t);
        return {{(SUM_W - TEMP_W){t[TEMP_W-1]}}, t};
    endfunction

endpackage

// File: rtl/lm75a_bin2bcd.sv
// Iterative double-dabble converter: one shift per cycle, INT_W cycles per conversion.
module lm75a_bin2bcd
    import lm75a_temp_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [INT_W-1:0]        bin_i,
    output logic [4*BCD_DIGITS-1:0] bcd_o,
    output logic                    last_o
);

    localparam int unsigned SH_W  = 4 * BCD_DIGITS + INT_W;
    localparam int unsigned CNT_W = $clog2(INT_W);

    logic [SH_W-1:0]  sh_q, sh_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    always_comb begin
        adj = sh_q;
        for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            if (adj[INT_W + 4*d +: 4] >= 4'd5) begin
                adj[INT_W + 4*d +: 4] = adj[INT_W + 4*d +: 4] + 4'd3;
            end
        end

        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            sh_d   = {{(4 * BCD_DIGITS){1'b0}}, bin_i};
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sh_d  = {adj[SH_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (last_o) begin
                busy_d = 1'b0;
            end
        end
    end

    assign last_o = busy_q && (cnt_q == CNT_W'(INT_W - 1));
    assign bcd_o  = sh_q[SH_W-1:INT_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/lm75a_temp_monitor.sv
// LM75A reading capture, optional 4-sample averaging (LM75A_TEMP_AVG_EN), BCD conversion
// and over-temperature alarm with hysteresis.
module lm75a_temp_monitor
    import lm75a_temp_pkg::*;
#(
    parameter logic signed [TEMP_W-1:0] T_OS   = T_OS_DEFAULT,
    parameter logic signed [TEMP_W-1:0] T_HYST = T_HYST_DEFAULT
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [TEMP_W-1:0]       Temp_data,
    input  logic                    Read_temp_en,
    output logic [TEMP_W-1:0]       Temp_avg,
    output logic                    Temp_sign,
    output logic [4*BCD_DIGITS-1:0] Temp_bcd,
    output logic [3:0]              Temp_frac,
    output logic                    Over_temp,
    output logic                    Temp_valid,
    output logic                    Busy
);

    logic [1:0]                state_q, state_d;
    logic                      rd_q;
    logic                      new_edge;
    logic                      pend_q, pend_d;
    logic [TEMP_W-1:0]         pend_data_q, pend_data_d;
    logic signed [TEMP_W-1:0]  sample_q, sample_d;
    logic signed [TEMP_W-1:0]  avg_q, avg_d, avg_new;
    logic [TEMP_W-1:0]         abs_new;
    logic [3:0]                frac_q, frac_d;
    logic                      conv_start, conv_last;
    logic [4*BCD_DIGITS-1:0]   conv_bcd;

    logic [TEMP_W-1:0]         temp_avg_q, temp_avg_d;
    logic                      temp_sign_q, temp_sign_d;
    logic [4*BCD_DIGITS-1:0]   temp_bcd_q, temp_bcd_d;
    logic [3:0]                temp_frac_q, temp_frac_d;
    logic                      over_temp_q, over_temp_d;
    logic                      temp_valid_q, temp_valid_d;

    assign new_edge = Read_temp_en & ~rd_q;

`ifdef LM75A_TEMP_AVG_EN
    logic signed [TEMP_W-1:0] win_q [4];
    logic signed [TEMP_W-1:0] win_d [4];
    logic [1:0]               ptr_q, ptr_d;
    logic                     primed_q, primed_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d, sum_new;

    // The first sample after reset fills the whole window so the average starts settled.
    always_comb begin
        win_d    = win_q;
        ptr_d    = ptr_q;
        primed_d = primed_q;
        sum_d    = sum_q;
        if (primed_q) begin
            sum_new = sum_q - sext_sum(win_q[ptr_q]) + sext_sum(sample_q);
        end else begin
            sum_new = sext_sum(sample_q) <<< 2;
        end
        if (state_q == ST_LOAD) begin
            sum_d    = sum_new;
            primed_d = 1'b1;
            if (primed_q) begin
                win_d[ptr_q] = sample_q;
                ptr_d        = ptr_q + 2'd1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    win_d[i] = sample_q;
                end
                ptr_d = 2'd0;
            end
        end
    end

    assign avg_new = sum_new[SUM_W-1:2];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 4; i++) begin
                win_q[i] <= '0;
            end
            ptr_q    <= 2'd0;
            primed_q <= 1'b0;
            sum_q    <= '0;
        end else begin
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            primed_q <= primed_d;
            sum_q    <= sum_d;
        end
    end
`else
    assign avg_new = sample_q;
`endif

    assign abs_new = temp_abs(avg_new);

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        sample_d     = sample_q;
        avg_d        = avg_q;
        frac_d       = frac_q;
        conv_start   = 1'b0;
        temp_avg_d   = temp_avg_q;
        temp_sign_d  = temp_sign_q;
        temp_bcd_d   = temp_bcd_q;
        temp_frac_d  = temp_frac_q;
        over_temp_d  = over_temp_q;
        temp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (new_edge) begin
                    sample_d = Temp_data;
                    pend_d   = 1'b0;
                    state_d  = ST_LOAD;
                end else if (pend_q) begin
                    sample_d = pend_data_q;
                    pend_d   = 1'b0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                avg_d      = avg_new;
                frac_d     = frac_tenths(abs_new[FRAC_BITS-1:0]);
                conv_start = 1'b1;
                state_d    = ST_CONV;
            end
            ST_CONV: begin
                if (conv_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                temp_avg_d   = avg_q;
                temp_sign_d  = avg_q[TEMP_W-1];
                temp_bcd_d   = conv_bcd;
                temp_frac_d  = frac_q;
                temp_valid_d = 1'b1;
                if (avg_q >= T_OS) begin
                    over_temp_d = 1'b1;
                end else if (avg_q < T_HYST) begin
                    over_temp_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // One-deep buffer; a later edge while busy replaces the earlier one.
        if (new_edge && (state_q != ST_IDLE)) begin
            pend_d      = 1'b1;
            pend_data_d = Temp_data;
        end
    end

    lm75a_bin2bcd u_bin2bcd (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .start_i (conv_start),
        .bin_i   (abs_new[TEMP_W-1:FRAC_BITS]),
        .bcd_o   (conv_bcd),
        .last_o  (conv_last)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= ST_IDLE;
            rd_q         <= 1'b0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            sample_q     <= '0;
            avg_q        <= '0;
            frac_q       <= '0;
            temp_avg_q   <= '0;
            temp_sign_q  <= 1'b0;
            temp_bcd_q   <= '0;
            temp_frac_q  <= '0;
            over_temp_q  <= 1'b0;
            temp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= Read_temp_en;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            sample_q     <= sample_d;
            avg_q        <= avg_d;
            frac_q       <= frac_d;
            temp_avg_q   <= temp_avg_d;
            temp_sign_q  <= temp_sign_d;
            temp_bcd_q   <= temp_bcd_d;
            temp_frac_q  <= temp_frac_d;
            over_temp_q  <= over_temp_d;
            temp_valid_q <= temp_valid_d;
        end
    end

    assign Temp_avg   = temp_avg_q;
    assign Temp_sign  = temp_sign_q;
    assign Temp_bcd   = temp_bcd_q;
    assign Temp_frac  = temp_frac_q;
    assign Over_temp  = over_temp_q;
    assign Temp_valid = temp_valid_q;
    assign Busy       = (state_q != ST_IDLE);

endmodule

// File: doc/lm75a_temp_monitor.md
# lm75a_temp_monitor

Downstream consumer of the LM75A driver. On each completed sensor read it captures the 11-bit two's-complement temperature (0.125 °C/LSB). It optionally averages the readings, then converts the result to sign, three BCD integer digits and one tenths digit. It also maintains an over-temperature alarm with hysteresis. Its outputs feed the display and the car-control logic.

## Interface
- T_OS, 11'sd640, alarm set threshold (0.125 °C units, 80.0 °C)
- T_HYST, 11'sd600, alarm clear threshold (75.0 °C); T_HYST < T_OS required
- Clk  in  1  system clock
- Rst_n  in  1  reset; asynchronous, active-low
- Temp_data  in  11  signed temperature from LM75A driver
- Read_temp_en  in  1  driver "read done"; pulse or level; only its rising edge counts
- Temp_avg  out  11  signed value used for conversion (averaged or raw)
- Temp_sign  out  1  1 = negative
- Temp_bcd  out  12  {hundreds, tens, units} of |T| integer part
- Temp_frac  out  4  tenths digit of |T|, truncated
- Over_temp  out  1  alarm
- Temp_valid  out  1  one-cycle pulse: outputs updated
- Busy  out  1  high in any state other than IDLE

## Operation
- Edge detect: rd_d <= Read_temp_en; new = Read_temp_en & ~rd_d.
- FSM states IDLE, LOAD, CONV, DONE:
  - IDLE: on new, capture Temp_data and go to LOAD. Otherwise, if pend is set, use pend_data, clear pend and go to LOAD.
  - LOAD: update the average. Compute abs = |avg| and sign. Set int = abs[10:3] (0..128) and frac3 = abs[2:0]. Load the bin2bcd engine. Go to CONV.
  - CONV: one double-dabble shift per cycle, 8 cycles. Go to DONE when the shift counter reaches 7.
  - DONE: register all outputs, update Over_temp, pulse Temp_valid, return to IDLE.
- Temp_frac = (frac3*5)>>2, giving the mapping 0,1,2,3,5,6,7,8.
- A new edge while not in IDLE sets pend and stores pend_data. The buffer is one deep and a later edge overwrites it. If new and pend are both present in IDLE, new wins and pend is cleared.
- Alarm uses the signed Temp_avg:
  - set when Temp_avg >= T_OS
  - clear when Temp_avg < T_HYST
  - otherwise hold
- Reset mid-operation: the FSM returns to IDLE, pend is cleared and the averaging window is emptied.
- Reset values of all outputs: Temp_avg = 0, Temp_sign = 0, Temp_bcd = 12'h000, Temp_frac = 0, Over_temp = 0, Temp_valid = 0, Busy = 0.

## Timing
- E0 is the Clk edge where new is sampled high in IDLE; the FSM enters LOAD.
- E1 enters CONV. E2..E9 perform the 8 shifts. E9 enters DONE.
- E10: outputs are updated and Temp_valid is high from E10 to E11. Latency from E0 to the valid pulse is 10 cycles.
- Busy is high from E0 through E10. The next conversion can start at E11 at the earliest; a pending sample also starts at E11.
- Outputs hold between Temp_valid pulses.

## Configuration
- LM75A_TEMP_AVG_EN defined:
  - Keep a 4-entry window of signed samples with a 13-bit signed running sum.
  - Temp_avg = sum >>> 2 (arithmetic shift, floor).
  - The first sample after reset fills all 4 entries.
  - Each later sample replaces the oldest entry.
- Undefined: Temp_avg = the captured sample. No window registers are built.

## Structure
- Package lm75a_temp_pkg holds:
  - FSM state enum
  - TEMP_W = 11, FRAC_BITS = 3, BCD_DIGITS = 3
  - default T_OS / T_HYST constants
- Sub-module lm75a_bin2bcd: an iterative 8-bit double-dabble converter with a start/done handshake, one shift per cycle, 12-bit BCD output. The top-level FSM drives it.

## Test plan
- Temp_data 11'h0C8 (25.0 °C) with a single rising edge → after 10 cycles Temp_valid pulses once; Temp_sign 0, Temp_bcd 12'h025, Temp_frac 0, Over_temp 0.
- 11'h7FF (−0.125 °C) → Temp_sign 1, Temp_bcd 12'h000, Temp_frac 1. Then 11'h3E8 → Temp_bcd 12'h125, Temp_frac 0. Then 11'h648 (−55.0 °C) → Temp_sign 1, Temp_bcd 12'h055.
- Without the macro: samples 640, 620, 599 → Over_temp goes to 1, stays 1, then goes to 0. Sample 639 after clearing → Over_temp stays 0.
- With LM75A_TEMP_AVG_EN: samples 200 then 208 → Temp_avg 200 then 202 (Temp_bcd 12'h025, Temp_frac 2). Samples −1, −1, −1, 0 after reset → Temp_avg −1 (floor).
- Three rising edges with data 100, 200, 300, the second and third arriving during Busy → exactly two Temp_valid pulses, showing 100 then 300.
- Rst_n asserted during CONV → all outputs return to reset values immediately and no Temp_valid pulse occurs. The next sample after reset primes the averaging window afresh.
